hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Replaces the fixed two-stage forwarding unit and the separate load-use hazard detector with one block.
- Tracks in-flight register writers over DEPTH post-ID stages (EX, MEM, WB at default). Each writer carries a per-instruction result latency.
- Produces the ID stall request and registered per-operand forwarding selects for the EX stage.

Parameters:
- NREG, 32, architectural register count; register 0 is hardwired zero.
- NSRC, 2, source operands per instruction.
- DEPTH, 3, tracked stages after ID (index 0 = EX ... DEPTH-1 = WB).
- AW, $clog2(NREG), register address width (derived).
- LW, $clog2(DEPTH+1), latency/select field width (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  NSRC*AW  source addresses, operand n at [n*AW +: AW].
- id_rs_used_i  in  NSRC  operand n is actually read.
- id_rd_i  in  AW  destination address.
- id_regwrite_i  in  1  instruction writes id_rd_i.
- id_lat_i  in  LW  stages after entering EX before the result is forwardable (ALU=1, load=2); range 1..DEPTH-1.
- flush_i  in  1  squash the ID instruction (taken branch/jump).
- stall_o  out  1  hold PC and IF/ID; insert bubble into EX (combinational).
- ex_fwd_sel_o  out  NSRC*LW  per-operand EX forwarding select (registered): 0 = register-file/ID_EX data, k = result of stage k.

Behaviour:
- State: DEPTH entries {valid, rd, lat}, shifted every cycle; entry[k] <= entry[k-1]. There is no global hold; the back pipeline always advances.
- Entry 0 load rule:
  - Load {1, id_rd_i, id_lat_i} when id_valid_i & id_regwrite_i & (id_rd_i != 0) & ~stall_o & ~flush_i.
  - Otherwise load a bubble (valid=0).
- Match search, per used source n with rs != 0: find the smallest j where entry[j].valid and entry[j].rd == rs.
  - Youngest writer wins; older matches are ignored.
- Hazard rule: at the instruction's EX cycle the producer sits at stage j+1.
  - If j+1 < entry[j].lat, operand n is a hazard.
  - Otherwise sel = j+1.
  - If j+1 == DEPTH, sel = 0 (the register file writes before it reads).
  - No match, unused operand, or rs == 0 gives sel = 0.
- stall_o = id_valid_i & ~flush_i & OR of the per-operand hazards.
  - A stall repeats each cycle until the hazard clears. A load followed by its consumer at default settings gives exactly 1 stall cycle.
- ex_fwd_sel_o register update:
  - Loaded with the computed selects when an instruction issues (id_valid_i & ~stall_o & ~flush_i).
  - Cleared to 0 on stall, flush or invalid.
- flush_i overrides stall: stall_o = 0, a bubble goes into entry 0, and the selects clear.
- Reset (asynchronous, any time, including mid-stall): all entries invalid, ex_fwd_sel_o = 0. stall_o is then 0 because no entries are valid.
- id_lat_i of 0 is treated as 1. Values >= DEPTH are illegal and flagged by a simulation-only assertion.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, the block adds ports:
  - perf_stall_cnt_o  out  32  cycles with stall_o=1.
  - perf_flush_cnt_o  out  32  cycles with flush_i=1.
  - perf_clr_i  in  1  synchronous clear of both counters.
- Counters saturate at 2^32-1 and reset to 0 on rst_i.
- When undefined, these ports and the counter logic do not exist and the block's behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - fwd_sel_t (LW-bit);
  - latency constants LAT_ALU=1, LAT_LOAD=2;
  - the sb_entry_t struct {valid, rd, lat};
  - constant FWD_REGFILE=0.
- One sub-module, hazard_match: the combinational per-operand youngest-match and hazard/select logic. It is instantiated NSRC times.

Test Plan:
- ALU-to-ALU: issue add x5,x1,x2 then add x6,x5,x3 -> stall_o=0; the second instruction's EX cycle has operand-0 select=1, operand-1 select=0.
- Load-use: lw x5 (lat 2) then add x6,x5,x5 -> stall_o=1 for exactly one cycle; on issue both selects=2; the EX stage sees one bubble.
- x0 and unused operand: lw x0 then add x6,x0,x0; also an unused source matching a pending rd -> stall_o=0, selects=0.
- Youngest wins: add x5 (ALU), then add x5, then add x7,x5,x5 -> selects=1, not 2. A writer at stage 2 with no younger match -> sel=0 at DEPTH=3.
- Flush vs stall: a load-use hazard present with flush_i=1 -> stall_o=0, a bubble enters entry 0, selects=0. Assert rst_i during a stall -> stall_o=0 and ex_fwd_sel_o=0 immediately; no hazards after release.
- HAZARD_PERF_EN: 3 load-use pairs plus 2 flushes -> perf_stall_cnt_o=3, perf_flush_cnt_o=2; after perf_clr_i both read 0.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types and constants for the in-order RISC-V core.
// Default widths match NREG=32, DEPTH=3; hazard_scoreboard re-derives its own widths from its parameters.
package cpu_pipe_pkg;

   localparam int unsigned NREG_DEF  = 32;
   localparam int unsigned DEPTH_DEF = 3;
   localparam int unsigned AW_DEF    = $clog2(NREG_DEF);
   localparam int unsigned LW_DEF    = $clog2(DEPTH_DEF + 1);

   typedef logic [LW_DEF-1:0] fwd_sel_t;

   localparam int unsigned LAT_ALU     = 1;
   localparam int unsigned LAT_LOAD    = 2;
   localparam int unsigned FWD_REGFILE = 0;

   typedef struct packed {
      logic              valid;
      logic [AW_DEF-1:0] rd;
      logic [LW_DEF-1:0] lat;
   } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-operand youngest-writer search over the tracked stages.
// Produces the hazard flag and the EX forwarding select for one source operand.
module hazard_match
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned AW    = 5,
   parameter int unsigned LW    = 2,
   parameter int unsigned DEPTH = 3
) (
   input  logic [AW-1:0]       rs,
   input  logic                used,
   input  logic [DEPTH-1:0]    ent_valid,
   input  logic [DEPTH*AW-1:0] ent_rd,
   input  logic [DEPTH*LW-1:0] ent_lat,
   output logic                hazard,
   output logic [LW-1:0]       sel
);

   logic found;

   // At the consumer's EX cycle the writer found at slot j sits one stage further on.
   always_comb begin
      hazard = 1'b0;
      sel    = LW'(FWD_REGFILE);
      found  = 1'b0;
      if (used && (rs != '0)) begin
         for (int unsigned j = 0; j < DEPTH; j++) begin
            if (!found && ent_valid[j] && (ent_rd[j*AW +: AW] == rs)) begin
               found = 1'b1;
               if ((j + 1) < 32'(ent_lat[j*LW +: LW])) begin
                  hazard = 1'b1;
               end else if ((j + 1) < DEPTH) begin
                  sel = LW'(j + 1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Unified hazard/forwarding controller: tracks in-flight writers, raises the ID stall, registers EX selects.
// Define HAZARD_PERF_EN to add saturating stall/flush performance counters.
module hazard_scoreboard
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned NREG  = 32,
   parameter int unsigned NSRC  = 2,
   parameter int unsigned DEPTH = 3,
   parameter int unsigned AW    = $clog2(NREG),
   parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 id_valid_i,
   input  logic [NSRC*AW-1:0]   id_rs_i,
   input  logic [NSRC-1:0]      id_rs_used_i,
   input  logic [AW-1:0]        id_rd_i,
   input  logic                 id_regwrite_i,
   input  logic [LW-1:0]        id_lat_i,
   input  logic                 flush_i,
   output logic                 stall_o,
   output logic [NSRC*LW-1:0]   ex_fwd_sel_o
`ifdef HAZARD_PERF_EN
   ,
   input  logic                 perf_clr_i,
   output logic [31:0]          perf_stall_cnt_o,
   output logic [31:0]          perf_flush_cnt_o
`endif
);

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rd;
      logic [LW-1:0] lat;
   } entry_t;

   entry_t ent [DEPTH];

   logic [DEPTH-1:0]    ent_valid;
   logic [DEPTH*AW-1:0] ent_rd;
   logic [DEPTH*LW-1:0] ent_lat;
   logic [NSRC-1:0]     op_hazard;
   logic [NSRC*LW-1:0]  sel_next;
   logic                issue;
   logic                load_e0;
   logic [LW-1:0]       lat_in;

   always_comb begin
      ent_valid = '0;
      ent_rd    = '0;
      ent_lat   = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
         ent_valid[j]         = ent[j].valid;
         ent_rd[j*AW +: AW]   = ent[j].rd;
         ent_lat[j*LW +: LW]  = ent[j].lat;
      end
   end

   for (genvar n = 0; n < NSRC; n++) begin : g_op
      hazard_match #(
         .AW    (AW),
         .LW    (LW),
         .DEPTH (DEPTH)
      ) u_match (
         .rs        (id_rs_i[n*AW +: AW]),
         .used      (id_rs_used_i[n]),
         .ent_valid (ent_valid),
         .ent_rd    (ent_rd),
         .ent_lat   (ent_lat),
         .hazard    (op_hazard[n]),
         .sel       (sel_next[n*LW +: LW])
      );
   end

   assign stall_o = id_valid_i & ~flush_i & (|op_hazard);
   assign issue   = id_valid_i & ~stall_o & ~flush_i;
   assign load_e0 = issue & id_regwrite_i & (id_rd_i != '0);
   assign lat_in  = (id_lat_i == '0) ? LW'(LAT_ALU) : id_lat_i;

   // The back pipeline never holds: a stall or flush simply feeds a bubble into slot 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            ent[k] <= '0;
         end
         ex_fwd_sel_o <= '0;
      end else begin
         ent[0] <= load_e0 ? '{valid: 1'b1, rd: id_rd_i, lat: lat_in} : '0;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            ent[k] <= ent[k-1];
         end
         ex_fwd_sel_o <= issue ? sel_next : '0;
      end
   end

   lat_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (id_valid_i && id_regwrite_i) |-> (32'(id_lat_i) < DEPTH));

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_stall_cnt_o <= '0;
         perf_flush_cnt_o <= '0;
      end else if (perf_clr_i) begin
         perf_stall_cnt_o <= '0;
         perf_flush_cnt_o <= '0;
      end else begin
         if (stall_o && (perf_stall_cnt_o != '1)) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
         end
         if (flush_i && (perf_flush_cnt_o != '1)) begin
            perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: driver queues hand-computed expectations, monitor checks each cycle.
// With HAZARD_PERF_EN defined the performance counters are checked as well.
module tb_hazard_scoreboard;

   localparam int unsigned NSRC = 2;
   localparam int unsigned AW   = 5;
   localparam int unsigned LW   = 2;

   logic                 clk = 1'b0;
   logic                 rst_i;
   logic                 id_valid_i;
   logic [NSRC*AW-1:0]   id_rs_i;
   logic [NSRC-1:0]      id_rs_used_i;
   logic [AW-1:0]        id_rd_i;
   logic                 id_regwrite_i;
   logic [LW-1:0]        id_lat_i;
   logic                 flush_i;
   logic                 stall_o;
   logic [NSRC*LW-1:0]   ex_fwd_sel_o;
`ifdef HAZARD_PERF_EN
   logic                 perf_clr_i;
   logic [31:0]          perf_stall_cnt_o;
   logic [31:0]          perf_flush_cnt_o;
`endif

   hazard_scoreboard #(
      .NREG  (32),
      .NSRC  (NSRC),
      .DEPTH (3)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .id_valid_i    (id_valid_i),
      .id_rs_i       (id_rs_i),
      .id_rs_used_i  (id_rs_used_i),
      .id_rd_i       (id_rd_i),
      .id_regwrite_i (id_regwrite_i),
      .id_lat_i      (id_lat_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o),
      .ex_fwd_sel_o  (ex_fwd_sel_o)
`ifdef HAZARD_PERF_EN
      ,
      .perf_clr_i       (perf_clr_i),
      .perf_stall_cnt_o (perf_stall_cnt_o),
      .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, v;
      logic [4:0] rs0, rs1;
      logic [1:0] used;
      logic [4:0] rd;
      logic       rw;
      logic [1:0] lat;
      logic       fl, clr;
      logic       es;
      logic [1:0] s0, s1;
   } vec_t;

   typedef struct {
      int         idx;
      logic       stall;
      logic [1:0] s0, s1;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // es = stall expected this cycle; s0/s1 = selects expected this cycle (set by the previous row's issue).
   task automatic row(input logic rst, v, input int rs0, rs1, u, rd, input logic rw, input int lat,
                      input logic fl, clr, es, input int s0, s1);
      vec_t r;
      r.rst = rst; r.v = v; r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(u);
      r.rd = 5'(rd); r.rw = rw; r.lat = 2'(lat); r.fl = fl; r.clr = clr;
      r.es = es; r.s0 = 2'(s0); r.s1 = 2'(s1);
      vecs.push_back(r);
   endtask

   task automatic bub(input int s0, s1, input logic clr = 1'b0);
      row(0, 0, 0, 0, 0, 0, 0, 0, 0, clr, 0, s0, s1);
   endtask

   task automatic build();
      row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset state
      row(0, 1, 1, 2, 3, 5, 1, 1, 0, 0, 0, 0, 0);  // add x5,x1,x2
      row(0, 1, 5, 3, 3, 6, 1, 1, 0, 0, 0, 0, 0);  // add x6,x5,x3
      bub(1, 0);
      bub(0, 0);
      row(0, 1, 1, 0, 1, 5, 1, 2, 0, 0, 0, 0, 0);  // lw x5
      row(0, 1, 5, 5, 3, 6, 1, 1, 0, 0, 1, 0, 0);  // add x6,x5,x5 stalls
      row(0, 1, 5, 5, 3, 6, 1, 1, 0, 0, 0, 0, 0);  // issues
      bub(2, 2);
      bub(0, 0);
      row(0, 1, 1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0);  // lw x0
      row(0, 1, 0, 0, 3, 6, 1, 1, 0, 0, 0, 0, 0);  // add x6,x0,x0
      row(0, 1, 1, 0, 1, 7, 1, 2, 0, 0, 0, 0, 0);  // lw x7
      row(0, 1, 2, 7, 1, 8, 1, 1, 0, 0, 0, 0, 0);  // unused rs1=x7
      bub(0, 0);
      bub(0, 0);
      row(0, 1, 1, 2, 3, 5, 1, 1, 0, 0, 0, 0, 0);  // add x5
      row(0, 1, 1, 2, 3, 5, 1, 1, 0, 0, 0, 0, 0);  // add x5 again
      row(0, 1, 5, 5, 3, 7, 1, 1, 0, 0, 0, 0, 0);  // add x7,x5,x5
      row(0, 1, 5, 7, 3, 9, 1, 1, 0, 0, 0, 1, 1);  // add x9,x5,x7
      row(0, 1, 5, 9, 1, 10, 1, 1, 0, 0, 0, 2, 1); // x5 at WB only
      bub(0, 0);
      bub(0, 0);
      row(0, 1, 1, 0, 1, 5, 1, 2, 0, 0, 0, 0, 0);  // lw x5
      row(0, 1, 5, 5, 3, 6, 1, 1, 1, 0, 0, 0, 0);  // consumer flushed
      row(0, 1, 6, 5, 3, 11, 1, 1, 0, 0, 0, 0, 0); // x6 must not be tracked
      row(0, 1, 11, 0, 1, 12, 1, 2, 0, 0, 0, 0, 2);// lw x12,(x11)
      row(0, 1, 12, 12, 3, 13, 1, 1, 0, 0, 1, 1, 0);
      row(1, 1, 12, 12, 3, 13, 1, 1, 0, 0, 0, 0, 0); // reset mid-stall
      row(0, 1, 12, 12, 3, 13, 1, 1, 0, 0, 0, 0, 0);
      row(0, 1, 13, 1, 3, 14, 1, 1, 0, 0, 0, 0, 0);
      bub(1, 0);
      row(0, 1, 0, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0);  // lat 0 acts as 1
      row(0, 1, 15, 0, 1, 16, 1, 1, 0, 0, 0, 0, 0);
      bub(1, 0);
      bub(0, 0, 1'b1);                              // counter clear
      for (int i = 0; i < 3; i++) begin
         row(0, 1, 1, 0, 1, 20, 1, 2, 0, 0, 0, (i == 0) ? 0 : 2, (i == 0) ? 0 : 2);
         row(0, 1, 20, 20, 3, 21, 1, 1, 0, 0, 1, 0, 0);
         row(0, 1, 20, 20, 3, 21, 1, 1, 0, 0, 0, 0, 0);
      end
      row(0, 1, 1, 0, 1, 22, 1, 1, 1, 0, 0, 2, 2);
      row(0, 1, 1, 0, 1, 22, 1, 1, 1, 0, 0, 0, 0);
      bub(0, 0);
   endtask

   // Monitor: every cycle the DUT presents stall_o and ex_fwd_sel_o; compare against queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (stall_o !== e.stall) begin
               n_bad++;
               $display("FAIL row%0d stall: got %0b expected %0b", e.idx, stall_o, e.stall);
            end
            n_vec++;
            if (ex_fwd_sel_o !== {e.s1, e.s0}) begin
               n_bad++;
               $display("FAIL row%0d sel: got op0=%0d op1=%0d expected op0=%0d op1=%0d",
                        e.idx, ex_fwd_sel_o[1:0], ex_fwd_sel_o[3:2], e.s0, e.s1);
            end
         end
      end
   end

   initial begin
      rst_i = 1'b1; id_valid_i = 1'b0; id_rs_i = '0; id_rs_used_i = '0;
      id_rd_i = '0; id_regwrite_i = 1'b0; id_lat_i = '0; flush_i = 1'b0;
`ifdef HAZARD_PERF_EN
      perf_clr_i = 1'b0;
`endif
      build();
      foreach (vecs[i]) begin
         @(negedge clk);
         rst_i         = vecs[i].rst;
         id_valid_i    = vecs[i].v;
         id_rs_i       = {vecs[i].rs1, vecs[i].rs0};
         id_rs_used_i  = vecs[i].used;
         id_rd_i       = vecs[i].rd;
         id_regwrite_i = vecs[i].rw;
         id_lat_i      = vecs[i].lat;
         flush_i       = vecs[i].fl;
`ifdef HAZARD_PERF_EN
         perf_clr_i    = vecs[i].clr;
`endif
         exp_q.push_back('{idx: i, stall: vecs[i].es, s0: vecs[i].s0, s1: vecs[i].s1});
      end
      #4;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
`ifdef HAZARD_PERF_EN
      n_vec++;
      if (perf_stall_cnt_o !== 32'd3) begin
         n_bad++;
         $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt_o);
      end
      n_vec++;
      if (perf_flush_cnt_o !== 32'd2) begin
         n_bad++;
         $display("FAIL perf_flush: got %0d expected 2", perf_flush_cnt_o);
      end
      @(negedge clk);
      perf_clr_i = 1'b1;
      @(negedge clk);
      perf_clr_i = 1'b0;
      #3;
      n_vec++;
      if ((perf_stall_cnt_o !== 32'd0) || (perf_flush_cnt_o !== 32'd0)) begin
         n_bad++;
         $display("FAIL perf_clr: got %0d/%0d expected 0/0", perf_stall_cnt_o, perf_flush_cnt_o);
      end
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
